// File: rtl/mem_stage_ctrl_pkg.sv
// Shared types and constants for the MEM-stage request/response controller.
package mem_stage_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_ctrl_state_t;

    typedef logic [1:0] lc3b_mem_be;

    localparam int unsigned MEM_TIMEOUT_DEFAULT = 32'd255;
    localparam int unsigned MEM_WORD_W          = 32'd16;

endpackage

// File: rtl/mem_wait_counter.sv
// Wait-cycle counter for an outstanding data-memory request; flags the last
// cycle before the request is abandoned.
module mem_wait_counter #(
    parameter int unsigned CNT_W          = 32'd8,
    parameter int unsigned TIMEOUT_CYCLES = 32'd255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic tc_o
);

    localparam bit          TO_EN  = (TIMEOUT_CYCLES != 32'd0);
    localparam int unsigned TC_INT = TO_EN ? (TIMEOUT_CYCLES - 32'd1) : 32'd0;
    localparam logic [CNT_W-1:0] TC_VAL = TC_INT[CNT_W-1:0];

    logic [CNT_W-1:0] cnt_q;

    // Clear has priority over increment so DONE/IDLE always restart from zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= {CNT_W{1'b0}};
        end else if (clr_i) begin
            cnt_q <= {CNT_W{1'b0}};
        end else if (inc_i) begin
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign tc_o = TO_EN && (cnt_q == TC_VAL);

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: turns decoded load/store control into a held
// request/response handshake on the data-memory port and stalls until done.
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = MEM_TIMEOUT_DEFAULT,
    parameter int unsigned CNT_W          = 32'd8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ctrl_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_byte_enable,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  logic        dmem_resp,
    input  logic [15:0] dmem_rdata,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [15:0] dmem_address,
    output logic [15:0] dmem_wdata,
    output logic [1:0]  dmem_byte_enable,
    output logic        stall,
    output logic [15:0] rdata_out,
    output logic        rdata_valid,
    output logic        timeout_err,
    output logic        protocol_err
);

    mem_ctrl_state_t state_q;
    logic            op_read_q;
    logic            dmem_read_q;
    logic            dmem_write_q;
    logic [15:0]     addr_q;
    logic [15:0]     wdata_q;
    lc3b_mem_be      be_q;
    logic [15:0]     rdata_q;
    logic            rdata_valid_q;
    logic            timeout_err_q;
    logic            protocol_err_q;

    logic req_s;
    logic in_access_s;
    logic tc_s;

    assign req_s       = ctrl_valid & (mem_read | mem_write);
    assign in_access_s = (state_q == ACCESS);

    mem_wait_counter #(
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wait_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (~in_access_s | dmem_resp),
        .inc_i   (in_access_s & ~dmem_resp),
        .tc_o    (tc_s)
    );

    // Request FSM with all port-side outputs registered; a simultaneous
    // read+write is demoted to a read and flagged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            op_read_q      <= 1'b0;
            dmem_read_q    <= 1'b0;
            dmem_write_q   <= 1'b0;
            addr_q         <= 16'h0000;
            wdata_q        <= 16'h0000;
            be_q           <= 2'b00;
            rdata_q        <= 16'h0000;
            rdata_valid_q  <= 1'b0;
            timeout_err_q  <= 1'b0;
            protocol_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    rdata_valid_q <= 1'b0;
                    if (req_s) begin
                        addr_q       <= addr;
                        wdata_q      <= wdata;
                        be_q         <= mem_byte_enable;
                        op_read_q    <= mem_read;
                        dmem_read_q  <= mem_read;
                        dmem_write_q <= mem_write & ~mem_read;
                        if (mem_read & mem_write) begin
                            protocol_err_q <= 1'b1;
                        end
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (dmem_resp) begin
                        dmem_read_q   <= 1'b0;
                        dmem_write_q  <= 1'b0;
                        rdata_valid_q <= op_read_q;
                        if (op_read_q) begin
                            rdata_q <= dmem_rdata;
                        end
                        state_q <= DONE;
                    end else if (tc_s) begin
                        dmem_read_q   <= 1'b0;
                        dmem_write_q  <= 1'b0;
                        rdata_valid_q <= op_read_q;
                        rdata_q       <= 16'h0000;
                        timeout_err_q <= 1'b1;
                        state_q       <= DONE;
                    end
                end
                DONE: begin
                    // The instruction still in EX/MEM advances at this edge; never re-accept it.
                    rdata_valid_q <= 1'b0;
                    state_q       <= IDLE;
                end
                default: begin
                    dmem_read_q   <= 1'b0;
                    dmem_write_q  <= 1'b0;
                    rdata_valid_q <= 1'b0;
                    state_q       <= IDLE;
                end
            endcase
        end
    end

    assign dmem_read        = dmem_read_q;
    assign dmem_write       = dmem_write_q;
    assign dmem_address     = addr_q;
    assign dmem_wdata       = wdata_q;
    assign dmem_byte_enable = be_q;
    assign rdata_out        = rdata_q;
    assign rdata_valid      = rdata_valid_q;
    assign timeout_err      = timeout_err_q;
    assign protocol_err     = protocol_err_q;
    assign stall            = reset_n & (((state_q == IDLE) & req_s) | in_access_s);

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: cycle-accurate stall/strobe checks
// plus a scoreboard of latched request fields.
module tb_mem_stage_ctrl;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
    } txn_t;

    logic        clk;
    logic        reset_n;
    logic        ctrl_valid;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_byte_enable;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        dmem_resp;
    logic [15:0] dmem_rdata;
    logic        dmem_read;
    logic        dmem_write;
    logic [15:0] dmem_address;
    logic [15:0] dmem_wdata;
    logic [1:0]  dmem_byte_enable;
    logic        stall;
    logic [15:0] rdata_out;
    logic        rdata_valid;
    logic        timeout_err;
    logic        protocol_err;

    int   errors;
    int   checks;
    txn_t sb[$];
    logic [15:0] last_rdata;

    mem_stage_ctrl #(
        .TIMEOUT_CYCLES (32'd4),
        .CNT_W          (32'd8)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .ctrl_valid       (ctrl_valid),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .mem_byte_enable  (mem_byte_enable),
        .addr             (addr),
        .wdata            (wdata),
        .dmem_resp        (dmem_resp),
        .dmem_rdata       (dmem_rdata),
        .dmem_read        (dmem_read),
        .dmem_write       (dmem_write),
        .dmem_address     (dmem_address),
        .dmem_wdata       (dmem_wdata),
        .dmem_byte_enable (dmem_byte_enable),
        .stall            (stall),
        .rdata_out        (rdata_out),
        .rdata_valid      (rdata_valid),
        .timeout_err      (timeout_err),
        .protocol_err     (protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running required done");
        $fatal(1, "watchdog expired");
    end

    task automatic drive(input logic v, input logic rd, input logic wr, input logic [1:0] be,
                         input logic [15:0] a, input logic [15:0] d);
        ctrl_valid = v; mem_read = rd; mem_write = wr; mem_byte_enable = be; addr = a; wdata = d;
    endtask

    task automatic pop_and_compare(input string name);
        txn_t t;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty at strobe", name);
        end else begin
            t = sb.pop_front();
            if ({dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable} !==
                {t.rd, t.wr, t.addr, t.wdata, t.be}) begin
                errors++;
                $display("FAIL %s: got rd=%b wr=%b a=%h d=%h be=%b required rd=%b wr=%b a=%h d=%h be=%b",
                         name, dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
                         t.rd, t.wr, t.addr, t.wdata, t.be);
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
        dmem_resp = 1'b0; dmem_rdata = 16'h0000;
        #12;
        checks++;
        if ({dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable, stall,
             rdata_out, rdata_valid, timeout_err, protocol_err} !== 56'h0) begin
            errors++;
            $display("FAIL reset_outputs: got rd=%b wr=%b a=%h rdata=%h st=%b te=%b pe=%b required all zero",
                     dmem_read, dmem_write, dmem_address, rdata_out, stall, timeout_err, protocol_err);
        end
        @(negedge clk); reset_n = 1'b1;
        last_rdata = 16'h0000;
    endtask

    task automatic test_nonmem();
        @(posedge clk); #1;
        for (int c = 0; c < 3; c++) begin
            if (c == 0) drive(1'b1, 1'b0, 1'b0, 2'b11, 16'h1111, 16'h2222);
            else        drive(1'b0, 1'b1, 1'b0, 2'b11, 16'h3333, 16'h2222);
            dmem_resp = (c == 2);
            @(negedge clk);
            checks++;
            if ({stall, dmem_read, dmem_write, rdata_valid} !== 4'b0000) begin
                errors++;
                $display("FAIL nonmem_c%0d: got st=%b rd=%b wr=%b rv=%b required 0000",
                         c, stall, dmem_read, dmem_write, rdata_valid);
            end
            @(posedge clk); #1;
        end
        drive(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000); dmem_resp = 1'b0;
    endtask

    task automatic test_load();
        @(posedge clk); #1;
        for (int c = 0; c <= 4; c++) begin
            drive(1'b1, 1'b1, 1'b0, 2'b11, 16'h0040, 16'h0000);
            if (c == 0) sb.push_back('{1'b1, 1'b0, 16'h0040, 16'h0000, 2'b11});
            dmem_resp = (c == 3); dmem_rdata = (c == 3) ? 16'hBEEF : 16'hDEAD;
            @(negedge clk);
            checks++;
            if ({stall, dmem_read, rdata_valid} !== {(c <= 3), (c >= 1 && c <= 3), (c == 4)}) begin
                errors++;
                $display("FAIL load_c%0d: got st=%b rd=%b rv=%b required st=%b rd=%b rv=%b", c,
                         stall, dmem_read, rdata_valid, (c <= 3), (c >= 1 && c <= 3), (c == 4));
            end
            if (c == 1) pop_and_compare("load_latch");
            if (c == 4) begin
                checks++;
                if (rdata_out !== 16'hBEEF) begin
                    errors++;
                    $display("FAIL load_rdata: got %h required beef", rdata_out);
                end
            end
            @(posedge clk); #1;
        end
        last_rdata = 16'hBEEF;
        drive(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000); dmem_resp = 1'b0;
    endtask

    task automatic test_store();
        @(posedge clk); #1;
        for (int c = 0; c <= 2; c++) begin
            drive(1'b1, 1'b0, 1'b1, 2'b11, 16'h0100, 16'h1234);
            if (c == 0) sb.push_back('{1'b0, 1'b1, 16'h0100, 16'h1234, 2'b11});
            dmem_resp = (c == 1); dmem_rdata = 16'h5555;
            @(negedge clk);
            checks++;
            if ({stall, dmem_write, dmem_read, rdata_valid} !== {(c <= 1), (c == 1), 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL store_c%0d: got st=%b wr=%b rd=%b rv=%b required st=%b wr=%b rd=0 rv=0",
                         c, stall, dmem_write, dmem_read, rdata_valid, (c <= 1), (c == 1));
            end
            if (c == 1) pop_and_compare("store_latch");
            if (c == 2) begin
                checks++;
                if (rdata_out !== last_rdata) begin
                    errors++;
                    $display("FAIL store_rdata_hold: got %h required %h", rdata_out, last_rdata);
                end
            end
            @(posedge clk); #1;
        end
        drive(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000); dmem_resp = 1'b0;
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        for (int c = 0; c <= 6; c++) begin
            if (c <= 2)      drive(1'b1, 1'b1, 1'b0, 2'b10, 16'h0200, 16'h0000);
            else if (c <= 5) drive(1'b1, 1'b0, 1'b1, 2'b01, 16'h0300, 16'h0F0F);
            else             drive(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
            if (c == 0) sb.push_back('{1'b1, 1'b0, 16'h0200, 16'h0000, 2'b10});
            if (c == 3) sb.push_back('{1'b0, 1'b1, 16'h0300, 16'h0F0F, 2'b01});
            dmem_resp = (c == 1 || c == 4); dmem_rdata = (c == 1) ? 16'hA5A5 : 16'h9999;
            @(negedge clk);
            checks++;
            if ({stall, dmem_read, dmem_write, rdata_valid} !==
                {(c == 0 || c == 1 || c == 3 || c == 4), (c == 1), (c == 4), (c == 2)}) begin
                errors++;
                $display("FAIL b2b_c%0d: got st=%b rd=%b wr=%b rv=%b", c, stall, dmem_read,
                         dmem_write, rdata_valid);
            end
            if (c == 1) pop_and_compare("b2b_load_latch");
            if (c == 4) pop_and_compare("b2b_store_latch");
            if (c == 2 || c == 5) begin
                checks++;
                if (rdata_out !== 16'hA5A5) begin
                    errors++;
                    $display("FAIL b2b_rdata_c%0d: got %h required a5a5", c, rdata_out);
                end
            end
            @(posedge clk); #1;
        end
        last_rdata = 16'hA5A5;
        dmem_resp = 1'b0;
    endtask

    task automatic test_timeout();
        @(posedge clk); #1;
        for (int c = 0; c <= 5; c++) begin
            drive(1'b1, 1'b1, 1'b0, 2'b11, 16'h0444, 16'h0000);
            dmem_resp = 1'b0; dmem_rdata = 16'hFFFF;
            @(negedge clk);
            checks++;
            if ({stall, dmem_read, timeout_err} !== {(c <= 4), (c >= 1 && c <= 4), (c == 5)}) begin
                errors++;
                $display("FAIL timeout_c%0d: got st=%b rd=%b te=%b required st=%b rd=%b te=%b", c,
                         stall, dmem_read, timeout_err, (c <= 4), (c >= 1 && c <= 4), (c == 5));
            end
            if (c == 5) begin
                checks++;
                if (rdata_out !== 16'h0000) begin
                    errors++;
                    $display("FAIL timeout_rdata: got %h required 0000", rdata_out);
                end
            end
            @(posedge clk); #1;
        end
        drive(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
        // Later traffic: a one-cycle write must leave the sticky flag set.
        @(posedge clk); #1;
        for (int c = 0; c <= 3; c++) begin
            if (c <= 2) drive(1'b1, 1'b0, 1'b1, 2'b11, 16'h0888, 16'h4321);
            else        drive(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
            dmem_resp = (c == 1);
            @(negedge clk);
            if (c == 3) begin
                checks++;
                if ({timeout_err, stall} !== 2'b10) begin
                    errors++;
                    $display("FAIL timeout_sticky: got te=%b st=%b required te=1 st=0", timeout_err, stall);
                end
            end
            @(posedge clk); #1;
        end
        dmem_resp = 1'b0;
    endtask

    task automatic test_reset_mid_access();
        @(posedge clk); #1;
        for (int c = 0; c <= 1; c++) begin
            drive(1'b1, 1'b0, 1'b1, 2'b01, 16'h0500, 16'hCAFE);
            if (c == 0) sb.push_back('{1'b0, 1'b1, 16'h0500, 16'hCAFE, 2'b01});
            dmem_resp = 1'b0;
            @(negedge clk);
            if (c == 1) pop_and_compare("rst_write_latch");
            @(posedge clk); #1;
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({dmem_write, stall, dmem_address} !== 18'h0) begin
            errors++;
            $display("FAIL rst_async: got wr=%b st=%b a=%h required 0 0 0000", dmem_write, stall, dmem_address);
        end
        drive(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1; dmem_resp = 1'b1; dmem_rdata = 16'h6666;
        @(negedge clk);
        @(posedge clk); #1; dmem_resp = 1'b0;
        @(negedge clk);
        checks++;
        if ({dmem_write, dmem_read, stall, rdata_valid, timeout_err} !== 5'b00000 ||
            rdata_out !== 16'h0000) begin
            errors++;
            $display("FAIL rst_late_resp: got wr=%b rd=%b st=%b rv=%b te=%b rdata=%h required zeros",
                     dmem_write, dmem_read, stall, rdata_valid, timeout_err, rdata_out);
        end
    endtask

    task automatic test_protocol();
        @(posedge clk); #1;
        for (int c = 0; c <= 2; c++) begin
            drive(1'b1, 1'b1, 1'b1, 2'b11, 16'h0600, 16'h0BAD);
            if (c == 0) sb.push_back('{1'b1, 1'b0, 16'h0600, 16'h0BAD, 2'b11});
            dmem_resp = (c == 1); dmem_rdata = 16'h7777;
            @(negedge clk);
            checks++;
            if ({stall, dmem_read, dmem_write, rdata_valid, protocol_err} !==
                {(c <= 1), (c == 1), 1'b0, (c == 2), (c >= 1)}) begin
                errors++;
                $display("FAIL protocol_c%0d: got st=%b rd=%b wr=%b rv=%b pe=%b", c, stall,
                         dmem_read, dmem_write, rdata_valid, protocol_err);
            end
            if (c == 1) pop_and_compare("protocol_latch");
            if (c == 2) begin
                checks++;
                if (rdata_out !== 16'h7777) begin
                    errors++;
                    $display("FAIL protocol_rdata: got %h required 7777", rdata_out);
                end
            end
            @(posedge clk); #1;
        end
        drive(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000); dmem_resp = 1'b0;
        @(negedge clk);
        checks++;
        if ({protocol_err, stall} !== 2'b10) begin
            errors++;
            $display("FAIL protocol_sticky: got pe=%b st=%b required pe=1 st=0", protocol_err, stall);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_nonmem();
        test_load();
        test_store();
        test_back_to_back();
        test_timeout();
        test_reset_mid_access();
        test_protocol();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
